// File: rtl/cdiv_pkg.sv
// -----------------------------------------------------------------------------
// cdiv_pkg
// Shared constants and types for the constant-division datapath (divide-by-113
// quotient/residue stage and its reconstructor).
//   DIVISOR : constant divisor (odd, 2..127)
//   D_W     : dividend width
//   Q_W     : quotient width, a multiple of DIGIT_W
//   R_W     : remainder width
//   DIGIT_W : quotient bits handled per cycle
//   NDIG    : number of digits per quotient
//   state_t : reconstructor FSM states
// -----------------------------------------------------------------------------
package cdiv_pkg;

  localparam int DIVISOR = 113;
  localparam int D_W     = 24;
  localparam int Q_W     = 18;
  localparam int R_W     = 7;
  localparam int DIGIT_W = 2;
  localparam int NDIG    = Q_W / DIGIT_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ADDREM = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage : cdiv_pkg

// File: rtl/cdiv_recon_if.sv
// -----------------------------------------------------------------------------
// cdiv_recon_if
// Handshake bundle of the reconstructor.
//   in_valid/in_ready/in_quot/in_rem      : quotient/remainder pair input
//   out_valid/out_ready/out_div/out_err   : reconstructed dividend output
// Modports:
//   master : the side that feeds pairs and consumes dividends
//   slave  : the reconstructor itself
// -----------------------------------------------------------------------------
interface cdiv_recon_if #(
  parameter int Q_W = cdiv_pkg::Q_W,
  parameter int R_W = cdiv_pkg::R_W,
  parameter int D_W = cdiv_pkg::D_W
);

  logic           in_valid;
  logic           in_ready;
  logic [Q_W-1:0] in_quot;
  logic [R_W-1:0] in_rem;
  logic           out_valid;
  logic           out_ready;
  logic [D_W-1:0] out_div;
  logic           out_err;

  modport master (
    output in_valid, in_quot, in_rem, out_ready,
    input  in_ready, out_valid, out_div, out_err
  );

  modport slave (
    input  in_valid, in_quot, in_rem, out_ready,
    output in_ready, out_valid, out_div, out_err
  );

endinterface : cdiv_recon_if

// File: rtl/cdiv_digit_mul.sv
// -----------------------------------------------------------------------------
// cdiv_digit_mul
// Combinational product of one quotient digit and the constant divisor.
// The result is DIGIT_W+R_W bits wide, which holds (2^DIGIT_W-1)*DIVISOR for
// any divisor below 2^R_W.
//   d    in  DIGIT_W        quotient digit
//   prod out DIGIT_W+R_W    d * DIVISOR
// For DIVISOR = 113 the product is built as (d<<7) - (d<<4) + d; any other
// divisor falls back to a generic constant multiply.
// -----------------------------------------------------------------------------
module cdiv_digit_mul #(
  parameter int DIGIT_W = cdiv_pkg::DIGIT_W,
  parameter int R_W     = cdiv_pkg::R_W,
  parameter int DIVISOR = cdiv_pkg::DIVISOR
) (
  input  logic [DIGIT_W-1:0]     d,
  output logic [DIGIT_W+R_W-1:0] prod
);

  localparam int P_W = DIGIT_W + R_W;

  logic [P_W-1:0] dz;

  assign dz = P_W'(d);

  if (DIVISOR == 113) begin : g_shift_add
    // 113 = 128 - 16 + 1; the intermediate may dip below zero modulo 2^P_W
    // but the final sum is always in range.
    assign prod = (dz << 7) - (dz << 4) + dz;
  end else begin : g_generic
    assign prod = dz * P_W'(DIVISOR);
  end

endmodule : cdiv_digit_mul

// File: rtl/cdiv_recon.sv
// -----------------------------------------------------------------------------
// cdiv_recon
// Digit-serial reconstructor: rebuilds D = q*DIVISOR + r, quotient MSB first,
// as the inverse of the long-division recurrence. Used as a round-trip check
// behind the divider and as a multiply-by-constant encoder.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : cdiv_recon_if.slave
//           in_valid/in_ready/in_quot/in_rem   pair input (accepted in IDLE)
//           out_valid/out_ready/out_div/out_err dividend output (held in DONE)
// Timing: acceptance on edge 0, digits on edges 1..NDIG, remainder added on
// edge NDIG+1, out_valid high from that edge until the out_ready handshake.
// Build option CDIV_RECON_CHECK_EN: when defined, out_err flags a remainder
// >= DIVISOR or a dividend overflowing D_W bits (one guard bit in acc); when
// undefined, out_err is 0 and acc wraps modulo 2^D_W.
// -----------------------------------------------------------------------------
module cdiv_recon #(
  parameter int DIVISOR = cdiv_pkg::DIVISOR,
  parameter int D_W     = cdiv_pkg::D_W,
  parameter int Q_W     = cdiv_pkg::Q_W,
  parameter int R_W     = cdiv_pkg::R_W,
  parameter int DIGIT_W = cdiv_pkg::DIGIT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  cdiv_recon_if.slave  bus
);

  import cdiv_pkg::*;

  localparam int NDIG  = Q_W / DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int P_W   = DIGIT_W + R_W;
`ifdef CDIV_RECON_CHECK_EN
  localparam int ACC_W = D_W + 1;
`else
  localparam int ACC_W = D_W;
`endif

  // Elaboration-time sanity of the number format.
  if ((Q_W % DIGIT_W) != 0) begin : g_bad_digit
    $error("cdiv_recon: Q_W must be a multiple of DIGIT_W");
  end
  if (((2 ** Q_W) - 1) * DIVISOR + (2 ** R_W) - 1 >= (2 ** (D_W + 1))) begin : g_bad_range
    $error("cdiv_recon: largest q*DIVISOR+r does not fit in D_W+1 bits");
  end

  state_t             state;
  logic [Q_W-1:0]     qsh;
  logic [R_W-1:0]     rem_q;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               out_valid_q;
  logic [D_W-1:0]     out_div_q;

  logic [DIGIT_W-1:0] digit;
  logic [P_W-1:0]     prod;
  logic [ACC_W-1:0]   acc_digit;
  logic [ACC_W-1:0]   acc_rem;

  assign digit = qsh[Q_W-1 -: DIGIT_W];

  cdiv_digit_mul #(
    .DIGIT_W (DIGIT_W),
    .R_W     (R_W),
    .DIVISOR (DIVISOR)
  ) u_digit_mul (
    .d    (digit),
    .prod (prod)
  );

  always_comb begin
    // NOTE: every combinational output gets a value on entry so no path can
    // leave it unassigned and infer a latch.
    acc_digit = '0;
    acc_rem   = '0;
    acc_digit = (acc << DIGIT_W) + ACC_W'(prod);
    acc_rem   = acc + ACC_W'(rem_q);
  end

`ifdef CDIV_RECON_CHECK_EN
  logic rem_bad;
  logic out_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift register and accumulator are reset along with the
      // control state so an aborted pair leaves nothing behind.
      state       <= IDLE;
      qsh         <= '0;
      rem_q       <= '0;
      acc         <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_div_q   <= '0;
`ifdef CDIV_RECON_CHECK_EN
      rem_bad     <= 1'b0;
      out_err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every register in this
      // block samples the pre-edge values of the others.
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            qsh   <= bus.in_quot;
            rem_q <= bus.in_rem;
            acc   <= '0;
            cnt   <= '0;
`ifdef CDIV_RECON_CHECK_EN
            rem_bad <= (bus.in_rem >= R_W'(DIVISOR));
`endif
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_digit;
          qsh <= qsh << DIGIT_W;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(NDIG - 1)) begin
            state <= ADDREM;
          end
        end
        ADDREM: begin
          acc         <= acc_rem;
          out_div_q   <= acc_rem[D_W-1:0];
          out_valid_q <= 1'b1;
`ifdef CDIV_RECON_CHECK_EN
          out_err_q   <= rem_bad | acc_rem[D_W];
`endif
          state       <= DONE;
        end
        DONE: begin
          // Outputs hold until the consumer takes them.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_div   = out_div_q;
`ifdef CDIV_RECON_CHECK_EN
  assign bus.out_err   = out_err_q;
`else
  assign bus.out_err   = 1'b0;
`endif

endmodule : cdiv_recon
